bbox_finder: RTL and testbench

- Upstream stage of the cropping block: scans the stored source image and computes the bounding box of foreground (dark) pixels.
- Presents the box as xMin/xMax/yMin/yMax, which the cropping stage consumes directly, and asserts done when the box is valid.
- Reads the same source pixel buffer that the cropping stage reads.
- Source buffer format: raw pixel array, no header, rows stored bottom-up, stride WIDTH*3 bytes, no row padding, byte order B,G,R.

---
 rtl/img_pkg.sv | 41 ++++
 rtl/bbox_finder_if.sv | 11 +
 rtl/bbox_accumulator.sv | 75 +++++++
 rtl/bbox_finder.sv | 190 +++++++++++++++++++
 tb/tb_bbox_finder.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Shared image-buffer types, widths and the source pixel address mapping.
package img_pkg;

  localparam int unsigned COORD_W         = 11;
  localparam int unsigned BYTES_PER_PIXEL = 3;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned THRESH_W        = 10;
  localparam int unsigned SUM_W           = 10;
  localparam int unsigned MARGIN_W        = 12;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    EVAL,
    FINAL,
    DONE
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
  } bbox_t;

  // Byte address of channel c of pixel (x, y); rows are stored bottom-up, B,G,R order.
  function automatic logic [ADDR_W-1:0] pixel_addr(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [1:0]         c,
    input int unsigned        width,
    input int unsigned        height
  );
    int unsigned row;
    row = height - 32'(y) - 32'd1;
    return ADDR_W'(row * width * BYTES_PER_PIXEL + 32'(x) * BYTES_PER_PIXEL + 32'(c));
  endfunction

endpackage

// File: rtl/bbox_finder_if.sv
// Read port into the shared source pixel buffer.
interface bbox_finder_if;

  logic [img_pkg::ADDR_W-1:0] readAddr;
  logic                       rden;
  logic [img_pkg::DATA_W-1:0] readdata;

  modport master (output readAddr, output rden, input readdata);
  modport slave  (input readAddr, input rden, output readdata);

endinterface

// File: rtl/bbox_accumulator.sv
// Running min/max of foreground pixel coordinates for one scan.
module bbox_accumulator
  import img_pkg::*;
#(
  parameter int unsigned WIDTH  = 100,
  parameter int unsigned HEIGHT = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               upd_en,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] minx,
  output logic [COORD_W-1:0] maxx,
  output logic [COORD_W-1:0] miny,
  output logic [COORD_W-1:0] maxy,
  output logic               hit
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

  logic [COORD_W-1:0] minx_q, minx_d;
  logic [COORD_W-1:0] maxx_q, maxx_d;
  logic [COORD_W-1:0] miny_q, miny_d;
  logic [COORD_W-1:0] maxy_q, maxy_d;
  logic               hit_q, hit_d;

  // Clear to an empty (inverted) box, or widen the box to include (x, y).
  always_comb begin
    minx_d = minx_q;
    maxx_d = maxx_q;
    miny_d = miny_q;
    maxy_d = maxy_q;
    hit_d  = hit_q;
    if (clear) begin
      minx_d = X_LAST;
      maxx_d = '0;
      miny_d = Y_LAST;
      maxy_d = '0;
      hit_d  = 1'b0;
    end else if (upd_en) begin
      hit_d = 1'b1;
      if (x < minx_q) minx_d = x;
      if (x > maxx_q) maxx_d = x;
      if (y < miny_q) miny_d = y;
      if (y > maxy_q) maxy_d = y;
    end
  end

  // Box registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      minx_q <= X_LAST;
      maxx_q <= '0;
      miny_q <= Y_LAST;
      maxy_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      minx_q <= minx_d;
      maxx_q <= maxx_d;
      miny_q <= miny_d;
      maxy_q <= maxy_d;
      hit_q  <= hit_d;
    end
  end

  assign minx = minx_q;
  assign maxx = maxx_q;
  assign miny = miny_q;
  assign maxy = maxy_q;
  assign hit  = hit_q;

endmodule

// File: rtl/bbox_finder.sv
// Scans the source image and publishes the bounding box of dark pixels.
module bbox_finder
  import img_pkg::*;
#(
  parameter int unsigned WIDTH  = 100,
  parameter int unsigned HEIGHT = 100,
  parameter int unsigned MARGIN = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [THRESH_W-1:0] thresh,
  bbox_finder_if.master       rd,
  output logic                done,
  output logic                found,
  output logic [COORD_W-1:0]  xMin,
  output logic [COORD_W-1:0]  xMax,
  output logic [COORD_W-1:0]  yMin,
  output logic [COORD_W-1:0]  yMax
);

  localparam logic [COORD_W-1:0]  X_LAST    = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0]  Y_LAST    = COORD_W'(HEIGHT - 1);
  localparam logic [MARGIN_W-1:0] MARGIN_M  = MARGIN_W'(MARGIN);
  localparam logic [MARGIN_W-1:0] X_LAST_M  = MARGIN_W'(WIDTH - 1);
  localparam logic [MARGIN_W-1:0] Y_LAST_M  = MARGIN_W'(HEIGHT - 1);
  localparam bbox_t               FULL_BOX  = '{x_min: '0, x_max: X_LAST, y_min: '0, y_max: Y_LAST};

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  x_q, x_d;
  logic [COORD_W-1:0]  y_q, y_d;
  logic [1:0]          c_q, c_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                done_q, done_d;
  logic                rden_q, rden_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                found_q, found_d;
  bbox_t               box_q, box_d;

  logic                acc_clear;
  logic                acc_upd;
  logic [COORD_W-1:0]  acc_minx, acc_maxx, acc_miny, acc_maxy;
  logic                acc_hit;
  bbox_t               clamp_box;

  logic [MARGIN_W:0]   x_lo_diff, y_lo_diff;
  logic [MARGIN_W-1:0] x_hi_sum, y_hi_sum;
  logic                unused_rd_hi;

  assign unused_rd_hi = ^rd.readdata[DATA_W-1:8];

  bbox_accumulator #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (acc_clear),
    .upd_en (acc_upd),
    .x      (x_q),
    .y      (y_q),
    .minx   (acc_minx),
    .maxx   (acc_maxx),
    .miny   (acc_miny),
    .maxy   (acc_maxy),
    .hit    (acc_hit)
  );

  // Grow the detected box by MARGIN and clamp it to the image; borrow bit flags underflow.
  always_comb begin
    x_lo_diff = {2'b00, acc_minx} - {1'b0, MARGIN_M};
    y_lo_diff = {2'b00, acc_miny} - {1'b0, MARGIN_M};
    x_hi_sum  = MARGIN_W'(acc_maxx) + MARGIN_M;
    y_hi_sum  = MARGIN_W'(acc_maxy) + MARGIN_M;
    clamp_box.x_min = x_lo_diff[MARGIN_W] ? '0 : COORD_W'(x_lo_diff);
    clamp_box.y_min = y_lo_diff[MARGIN_W] ? '0 : COORD_W'(y_lo_diff);
    clamp_box.x_max = (x_hi_sum > X_LAST_M) ? X_LAST : COORD_W'(x_hi_sum);
    clamp_box.y_max = (y_hi_sum > Y_LAST_M) ? Y_LAST : COORD_W'(y_hi_sum);
  end

  // Scan sequencer: next state, counters, accumulator controls and next output values.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    c_d       = c_q;
    sum_d     = sum_q;
    found_d   = found_q;
    box_d     = box_q;
    acc_clear = 1'b0;
    acc_upd   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          x_d       = '0;
          y_d       = '0;
          c_d       = '0;
          sum_d     = '0;
          acc_clear = 1'b1;
          state_d   = READ;
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        sum_d = sum_q + SUM_W'(rd.readdata[7:0]);
        if (c_q != 2'd2) begin
          c_d     = c_q + 2'd1;
          state_d = READ;
        end else begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (sum_q < thresh) acc_upd = 1'b1;
        sum_d = '0;
        c_d   = '0;
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            state_d = FINAL;
          end else begin
            y_d     = y_q + COORD_W'(1);
            state_d = READ;
          end
        end else begin
          x_d     = x_q + COORD_W'(1);
          state_d = READ;
        end
      end
      FINAL: begin
        if (acc_hit) begin
          box_d   = clamp_box;
          found_d = 1'b1;
        end else begin
          box_d   = FULL_BOX;
          found_d = 1'b0;
        end
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    rden_d = (state_d == READ);
    addr_d = rden_d ? pixel_addr(x_d, y_d, c_d, WIDTH, HEIGHT) : '0;
  end

  // State, counters and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      rden_q  <= 1'b0;
      addr_q  <= '0;
      found_q <= 1'b0;
      box_q   <= FULL_BOX;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      rden_q  <= rden_d;
      addr_q  <= addr_d;
      found_q <= found_d;
      box_q   <= box_d;
    end
  end

  assign rd.readAddr = addr_q;
  assign rd.rden     = rden_q;
  assign done        = done_q;
  assign found       = found_q;
  assign xMin        = box_q.x_min;
  assign xMax        = box_q.x_max;
  assign yMin        = box_q.y_min;
  assign yMax        = box_q.y_max;

endmodule

// File: tb/tb_bbox_finder.sv
// Scoreboard bench for bbox_finder: MARGIN=0 and MARGIN=2 instances share one source image.
module tb_bbox_finder;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NB   = W * H * 3;
  localparam int SCAN = 7 * W * H + 1;

  typedef struct {
    logic        found;
    logic [10:0] x0;
    logic [10:0] x1;
    logic [10:0] y0;
    logic [10:0] y1;
  } res_t;

  typedef struct {
    res_t r;
    int   edge_no;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] thresh;

  logic        done0, found0, done2, found2;
  logic [10:0] xmin0, xmax0, ymin0, ymax0;
  logic [10:0] xmin2, xmax2, ymin2, ymax2;

  bbox_finder_if rd0 ();
  bbox_finder_if rd2 ();

  bbox_finder #(.WIDTH(W), .HEIGHT(H), .MARGIN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .thresh(thresh), .rd(rd0),
    .done(done0), .found(found0), .xMin(xmin0), .xMax(xmax0), .yMin(ymin0), .yMax(ymax0)
  );

  bbox_finder #(.WIDTH(W), .HEIGHT(H), .MARGIN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .thresh(thresh), .rd(rd2),
    .done(done2), .found(found2), .xMin(xmin2), .xMax(xmax2), .yMin(ymin2), .yMax(ymax2)
  );

  always #5 clk = ~clk;

  // Image as (x, y) pixels; the byte buffer is derived from it in file layout.
  int         pb[H][W];
  int         pg[H][W];
  int         pr[H][W];
  logic [7:0] mem[NB];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  res_t held[2];
  logic prev_done[2] = '{1'b0, 1'b0};
  int   rdk[2] = '{0, 0};
  int   waitc[2] = '{0, 0};
  bit   end_req = 1'b0;
  bit   end_ack[2] = '{1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (a < 32'(NB)) return mem[a];
    return 8'h00;
  endfunction

  // Source buffer: one-cycle read latency, upper data bits are junk.
  always @(posedge clk) begin
    if (rd0.rden) rd0.readdata <= {8'($urandom), mem_rd(rd0.readAddr)};
    if (rd2.rden) rd2.readdata <= {8'($urandom), mem_rd(rd2.readAddr)};
  end

  function automatic res_t reset_res();
    res_t r;
    r.found = 1'b0; r.x0 = 11'd0; r.x1 = 11'(W - 1); r.y0 = 11'd0; r.y1 = 11'(H - 1);
    return r;
  endfunction

  // Reference: scan all pixels, collect foreground extents, pad and clamp.
  function automatic res_t model(input int margin, input int th);
    res_t r;
    int lx, hx, ly, hy;
    bit any;
    any = 0; lx = W; hx = -1; ly = H; hy = -1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (pb[y][x] + pg[y][x] + pr[y][x] < th) begin
          any = 1;
          if (x < lx) lx = x;
          if (x > hx) hx = x;
          if (y < ly) ly = y;
          if (y > hy) hy = y;
        end
    if (!any) return reset_res();
    lx = (lx - margin < 0) ? 0 : lx - margin;
    ly = (ly - margin < 0) ? 0 : ly - margin;
    hx = (hx + margin > W - 1) ? W - 1 : hx + margin;
    hy = (hy + margin > H - 1) ? H - 1 : hy + margin;
    r.found = 1'b1; r.x0 = 11'(lx); r.x1 = 11'(hx); r.y0 = 11'(ly); r.y1 = 11'(hy);
    return r;
  endfunction

  function automatic string rstr(input res_t r);
    return $sformatf("found=%0b box=(%0d,%0d,%0d,%0d)", r.found, r.x0, r.x1, r.y0, r.y1);
  endfunction

  function automatic bit rsame(input res_t a, input res_t b);
    return (a.found === b.found) && (a.x0 === b.x0) && (a.x1 === b.x1) &&
           (a.y0 === b.y0) && (a.y1 === b.y1);
  endfunction

  function automatic void chk(input bit ok, input string name, input string act, input string req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %s, expected %s", name, cyc, act, req);
    end
  endfunction

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int id);
    if (id == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void qclear(input int id);
    if (id == 0) q0.delete();
    else q1.delete();
  endfunction

  // Monitor for one instance: reset state, read order, result on done rise, hold otherwise.
  task automatic mon(input int id, input logic dn, input logic rdn, input logic [31:0] ad, input res_t act);
    string nm;
    nm = (id == 0) ? "m0" : "m2";
    if (!rst_n) begin
      qclear(id);
      held[id]  = reset_res();
      rdk[id]   = 0;
      waitc[id] = 0;
      chk(dn === 1'b0 && rdn === 1'b0 && ad === 32'd0, {nm, "_reset_ctl"},
          $sformatf("done=%b rden=%b addr=%0d", dn, rdn, ad), "done=0 rden=0 addr=0");
      chk(rsame(act, held[id]), {nm, "_reset_box"}, rstr(act), rstr(held[id]));
      prev_done[id] = dn;
      return;
    end
    if (rdn === 1'b1) begin
      int k, c, p, x, y, ea;
      k = rdk[id]; c = k % 3; p = k / 3; x = p % W; y = p / W;
      ea = ((H - 1 - y) * W + x) * 3 + c;
      chk(ad === 32'(ea), {nm, "_read_addr"}, $sformatf("%0d", ad), $sformatf("%0d (x=%0d y=%0d c=%0d)", ea, x, y, c));
      rdk[id] = (k + 1) % NB;
    end
    if (dn === 1'b1 && prev_done[id] !== 1'b1) begin
      if (qsize(id) == 0) begin
        chk(1'b0, {nm, "_unexpected_done"}, "done rose", "no pending scan");
      end else begin
        exp_t e;
        e = qpop(id);
        chk(rsame(act, e.r), {nm, "_result"}, rstr(act), rstr(e.r));
        chk(cyc == e.edge_no, {nm, "_done_edge"}, $sformatf("%0d", cyc), $sformatf("%0d", e.edge_no));
        chk(rdk[id] == 0, {nm, "_read_count"}, $sformatf("%0d leftover", rdk[id]), "0 leftover");
        held[id] = e.r;
      end
      waitc[id] = 0;
    end else begin
      chk(rsame(act, held[id]), {nm, "_hold"}, rstr(act), rstr(held[id]));
    end
    if (qsize(id) != 0) begin
      waitc[id]++;
      if (waitc[id] > SCAN + 50) begin
        chk(1'b0, {nm, "_done_timeout"}, "no done", "done within scan time");
        qclear(id);
        waitc[id] = 0;
      end
    end
    if (end_req && !end_ack[id]) begin
      chk(qsize(id) == 0, {nm, "_drain"}, $sformatf("%0d pending", qsize(id)), "0 pending");
      end_ack[id] = 1'b1;
    end
    prev_done[id] = dn;
  endtask

  always @(negedge clk) begin
    res_t a0, a2;
    a0.found = found0; a0.x0 = xmin0; a0.x1 = xmax0; a0.y0 = ymin0; a0.y1 = ymax0;
    a2.found = found2; a2.x0 = xmin2; a2.x1 = xmax2; a2.y0 = ymin2; a2.y1 = ymax2;
    mon(0, done0, rd0.rden, rd0.readAddr, a0);
    mon(1, done2, rd2.rden, rd2.readAddr, a2);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fill(input int b, input int g, input int r);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        pb[y][x] = b; pg[y][x] = g; pr[y][x] = r;
      end
  endtask

  task automatic set_px(input int x, input int y, input int b, input int g, input int r);
    pb[y][x] = b; pg[y][x] = g; pr[y][x] = r;
  endtask

  task automatic random_image();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if ($urandom_range(0, 9) == 0)
          set_px(x, y, $urandom_range(0, 120), $urandom_range(0, 120), $urandom_range(0, 120));
        else
          set_px(x, y, $urandom_range(90, 255), $urandom_range(90, 255), $urandom_range(90, 255));
  endtask

  task automatic build_mem();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int base;
        base = (H - 1 - y) * W * 3 + x * 3;
        mem[base]     = 8'(pb[y][x]);
        mem[base + 1] = 8'(pg[y][x]);
        mem[base + 2] = 8'(pr[y][x]);
      end
  endtask

  // Launch a scan (expectations pushed first) and optionally poke start mid-scan.
  task automatic launch(input int th, input bit mid_pulse);
    exp_t e0, e2;
    build_mem();
    thresh = 10'(th);
    e0.r = model(0, th); e0.edge_no = cyc + 1 + SCAN;
    e2.r = model(2, th); e2.edge_no = cyc + 1 + SCAN;
    q0.push_back(e0);
    q1.push_back(e2);
    start = 1'b1;
    step();
    start = 1'b0;
    if (mid_pulse) begin
      repeat (50) step();
      start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2 * SCAN; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      step();
    end
    repeat (3) step();
  endtask

  task automatic scan(input int th, input bit mid_pulse);
    launch(th, mid_pulse);
    wait_drain();
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    thresh = 10'd0;
    fill(255, 255, 255);
    build_mem();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Blank image: no foreground, full frame.
    fill(255, 255, 255);
    scan(384, 1'b0);

    // Single dark pixel.
    fill(255, 255, 255);
    set_px(3, 2, 0, 0, 0);
    scan(384, 1'b0);

    // Dark rectangle touching the top edge.
    fill(255, 255, 255);
    for (int y = 0; y <= 4; y++)
      for (int x = 1; x <= 5; x++) set_px(x, y, 10, 20, 30);
    scan(384, 1'b0);

    // Threshold boundary: sum == thresh is background, one below is foreground.
    fill(255, 255, 255);
    set_px(2, 1, 128, 128, 128);
    set_px(4, 4, 128, 128, 127);
    scan(384, 1'b0);

    // thresh = 0 never matches, even on black.
    fill(0, 0, 0);
    scan(0, 1'b0);

    // Largest sums: 764 < 765 hits, 765 does not.
    fill(255, 255, 255);
    set_px(7, 5, 255, 255, 254);
    scan(765, 1'b0);

    // Every pixel foreground.
    fill(255, 255, 255);
    scan(1023, 1'b0);

    // Random images, one with a start pulse mid-scan that must be ignored.
    for (int n = 0; n < 4; n++) begin
      random_image();
      scan($urandom_range(200, 450), n == 1);
    end

    // Reset mid-scan, then rescan the same image.
    random_image();
    set_px(6, 0, 0, 0, 0);
    begin
      int th;
      th = $urandom_range(250, 400);
      launch(th, 1'b0);
      repeat (99) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      scan(th, 1'b0);
    end

    end_req = 1'b1;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
